// File: rtl/mac_seq.sv
// mac_seq: walks paired data/weight buffers, streams FP16 operand pairs into an
// external MAC unit one at a time, then writes the MAC's final result to an
// output address.
// Optional feature: define MAC_SEQ_RELU_EN to write zero instead of any result
// whose sign bit is set.
`timescale 1ns/1ps
module mac_seq #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_data_base,
    input  logic [ADDR_W-1:0] cmd_weight_base,
    input  logic [ADDR_W-1:0] cmd_out_addr,
    input  logic [CNT_W-1:0]  cmd_len,
    output logic              data_rd_en,
    output logic [ADDR_W-1:0] data_rd_addr,
    input  logic [15:0]       data_rd_data,
    output logic              weight_rd_en,
    output logic [ADDR_W-1:0] weight_rd_addr,
    input  logic [15:0]       weight_rd_data,
    output logic              mac_start,
    output logic [31:0]       mac_op_num,
    output logic [15:0]       mac_data,
    output logic [15:0]       mac_weight,
    input  logic              mac_take,
    input  logic              mac_done,
    input  logic [15:0]       mac_result,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [15:0]       out_wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT_TAKE,
        WAIT_RES,
        WRITE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] data_base;
    logic [ADDR_W-1:0] weight_base;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_nxt;
    logic [15:0]       res_wr;

    // Next pair index and the value that will be written back for the MAC result
    always_comb begin
        idx_nxt = idx + CNT_W'(1);
`ifdef MAC_SEQ_RELU_EN
        res_wr = mac_result[15] ? 16'h0000 : mac_result;
`else
        res_wr = mac_result;
`endif
    end

    // Sequencer FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            data_rd_en     <= 1'b0;
            weight_rd_en   <= 1'b0;
            data_rd_addr   <= '0;
            weight_rd_addr <= '0;
            mac_start      <= 1'b0;
            mac_op_num     <= '0;
            mac_data       <= '0;
            mac_weight     <= '0;
            out_wr_en      <= 1'b0;
            out_wr_addr    <= '0;
            out_wr_data    <= '0;
            data_base      <= '0;
            weight_base    <= '0;
            out_addr       <= '0;
            len            <= '0;
            idx            <= '0;
        end else begin
            data_rd_en   <= 1'b0;
            weight_rd_en <= 1'b0;
            mac_start    <= 1'b0;
            out_wr_en    <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        data_base   <= cmd_data_base;
                        weight_base <= cmd_weight_base;
                        out_addr    <= cmd_out_addr;
                        len         <= cmd_len;
                        idx         <= '0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_len == '0) begin
                            // Empty job: skip the MAC entirely and write zero
                            out_wr_en   <= 1'b1;
                            out_wr_addr <= cmd_out_addr;
                            out_wr_data <= 16'h0000;
                            done        <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            data_rd_en     <= 1'b1;
                            weight_rd_en   <= 1'b1;
                            data_rd_addr   <= cmd_data_base;
                            weight_rd_addr <= cmd_weight_base;
                            state          <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    mac_data   <= data_rd_data;
                    mac_weight <= weight_rd_data;
                    if (idx == '0) begin
                        mac_start  <= 1'b1;
                        mac_op_num <= 32'(len - CNT_W'(1));
                        state      <= START;
                    end else begin
                        state <= WAIT_TAKE;
                    end
                end
                START: begin
                    state <= WAIT_TAKE;
                end
                WAIT_TAKE: begin
                    if (mac_take) begin
                        idx <= idx_nxt;
                        if (idx_nxt < len) begin
                            data_rd_en     <= 1'b1;
                            weight_rd_en   <= 1'b1;
                            data_rd_addr   <= data_base + ADDR_W'(idx_nxt);
                            weight_rd_addr <= weight_base + ADDR_W'(idx_nxt);
                            state          <= FETCH;
                        end else begin
                            state <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    if (mac_done) begin
                        out_wr_en   <= 1'b1;
                        out_wr_addr <= out_addr;
                        out_wr_data <= res_wr;
                        done        <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: buffer models, a simple integer MAC emulator and a
// queue-based scoreboard for reads, MAC starts, consumed operands and writes.
`timescale 1ns/1ps
module tb_mac_seq;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_data_base;
    logic [ADDR_W-1:0] cmd_weight_base;
    logic [ADDR_W-1:0] cmd_out_addr;
    logic [CNT_W-1:0]  cmd_len;
    logic              data_rd_en;
    logic [ADDR_W-1:0] data_rd_addr;
    logic [15:0]       data_rd_data;
    logic              weight_rd_en;
    logic [ADDR_W-1:0] weight_rd_addr;
    logic [15:0]       weight_rd_data;
    logic              mac_start;
    logic [31:0]       mac_op_num;
    logic [15:0]       mac_data;
    logic [15:0]       mac_weight;
    logic              mac_take;
    logic              mac_done;
    logic [15:0]       mac_result;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [15:0]       out_wr_data;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] dmem [0:4095];
    logic [15:0] wmem [0:4095];

    logic [23:0] exp_rd_q[$];
    logic [31:0] exp_start_q[$];
    logic [31:0] exp_op_q[$];
    logic [27:0] exp_wr_q[$];

    always #5 clk = ~clk;

    mac_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data_base(cmd_data_base), .cmd_weight_base(cmd_weight_base),
        .cmd_out_addr(cmd_out_addr), .cmd_len(cmd_len),
        .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
        .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .weight_rd_data(weight_rd_data),
        .mac_start(mac_start), .mac_op_num(mac_op_num),
        .mac_data(mac_data), .mac_weight(mac_weight),
        .mac_take(mac_take), .mac_done(mac_done), .mac_result(mac_result),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read buffers: data valid the cycle after rd_en
    always @(posedge clk) begin
        if (data_rd_en)   data_rd_data   <= dmem[data_rd_addr];
        if (weight_rd_en) weight_rd_data <= wmem[weight_rd_addr];
    end

    // MAC emulator: integer multiply-accumulate, takes a pair every 4 cycles
    logic        model_take, model_done, model_active, stray_done;
    logic [15:0] model_res, acc;
    int unsigned remaining, timer;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_active <= 1'b0; model_take <= 1'b0; model_done <= 1'b0;
            remaining <= 0; timer <= 0; acc <= '0; model_res <= '0;
        end else begin
            model_take <= 1'b0;
            model_done <= 1'b0;
            if (mac_start) begin
                model_active <= 1'b1; remaining <= mac_op_num + 1; timer <= 3; acc <= '0;
            end else if (model_active) begin
                if (timer != 0) timer <= timer - 1;
                else if (remaining != 0) begin
                    model_take <= 1'b1;
                    acc        <= acc + 16'(mac_data * mac_weight);
                    remaining  <= remaining - 1;
                    timer      <= 3;
                end else begin
                    model_done   <= 1'b1;
                    model_res    <= acc;
                    model_active <= 1'b0;
                end
            end
        end
    end
    assign mac_take   = model_take;
    assign mac_done   = model_done | stray_done;
    assign mac_result = stray_done ? 16'hDEAD : model_res;

    // Scoreboard monitor: pops expectations as the DUT produces events
    always @(negedge clk) begin
        if (!rst) begin
            if (data_rd_en || weight_rd_en) begin
                check("rd_expected", 32'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) begin
                    logic [23:0] e;
                    e = exp_rd_q.pop_front();
                    check("rd_en_pair", {data_rd_en, weight_rd_en}, 2'b11);
                    check("data_rd_addr", data_rd_addr, e[23:12]);
                    check("weight_rd_addr", weight_rd_addr, e[11:0]);
                end
            end
            if (mac_start) begin
                check("start_expected", 32'(exp_start_q.size() != 0), 1);
                if (exp_start_q.size() != 0) check("mac_op_num", mac_op_num, exp_start_q.pop_front());
            end
            if (mac_take) begin
                check("take_expected", 32'(exp_op_q.size() != 0), 1);
                if (exp_op_q.size() != 0) check("operand_pair", {mac_data, mac_weight}, exp_op_q.pop_front());
            end
            if (out_wr_en || done) begin
                check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
                if (exp_wr_q.size() != 0) begin
                    logic [27:0] w;
                    w = exp_wr_q.pop_front();
                    check("wr_done_together", {out_wr_en, done}, 2'b11);
                    check("out_wr_addr", out_wr_addr, w[27:16]);
                    check("out_wr_data", out_wr_data, w[15:0]);
                end
            end
        end
    end

    task automatic push_job(input logic [11:0] db, input logic [11:0] wb,
                            input logic [11:0] oa, input logic [15:0] ln);
        logic [15:0] sum;
        sum = '0;
        for (int i = 0; i < int'(ln); i++) begin
            logic [11:0] da, wa;
            da = db + 12'(i);
            wa = wb + 12'(i);
            exp_rd_q.push_back({da, wa});
            exp_op_q.push_back({dmem[da], wmem[wa]});
            sum = sum + 16'(dmem[da] * wmem[wa]);
        end
        if (ln != 0) exp_start_q.push_back(32'(ln - 16'd1));
`ifdef MAC_SEQ_RELU_EN
        if (sum[15]) sum = 16'h0000;
`endif
        exp_wr_q.push_back({oa, sum});
    endtask

    // Offer a command and return just after the accepting edge
    task automatic issue(input logic [11:0] db, input logic [11:0] wb,
                         input logic [11:0] oa, input logic [15:0] ln, input bit hold);
        bit ok;
        ok = 1'b0;
        cmd_data_base = db; cmd_weight_base = wb; cmd_out_addr = oa; cmd_len = ln;
        cmd_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(ok), 1);
        #1;
        if (!hold) cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("ready_after_accept", 32'(cmd_ready), 0);
    endtask

    task automatic wait_done(output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                cycles = c + 1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("idle_ready", 32'(cmd_ready), 1);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic check_queues_empty();
        check("rd_q_empty", exp_rd_q.size(), 0);
        check("start_q_empty", exp_start_q.size(), 0);
        check("op_q_empty", exp_op_q.size(), 0);
        check("wr_q_empty", exp_wr_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int early;
        bit seen;
        rst = 1'b1; cmd_valid = 1'b0; stray_done = 1'b0;
        cmd_data_base = '0; cmd_weight_base = '0; cmd_out_addr = '0; cmd_len = '0;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = 16'($urandom_range(0, 255));
            wmem[i] = 16'($urandom_range(0, 255));
        end
        dmem[12'h300] = 16'h0001;
        wmem[12'h400] = 16'hBC00;
        dmem[12'h310] = 16'h0001;
        wmem[12'h410] = 16'h3C00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_outputs", {cmd_ready, busy, done, data_rd_en, weight_rd_en, mac_start, out_wr_en}, 7'b1000000);
        check("rst_addrs", {data_rd_addr, weight_rd_addr, out_wr_addr}, '0);
        check("rst_data", {mac_data, mac_weight}, '0);
        check("rst_op_num", mac_op_num, '0);
        check("rst_wr_data", out_wr_data, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_busy", 32'(busy), 0);

        // Three-pair job
        push_job(12'h010, 12'h020, 12'h005, 16'd3);
        issue(12'h010, 12'h020, 12'h005, 16'd3, 1'b0);
        wait_done(cyc);
        check_queues_empty();

        // Empty job: zero written without touching buffers or MAC
        push_job(12'h111, 12'h222, 12'h0AB, 16'd0);
        issue(12'h111, 12'h222, 12'h0AB, 16'd0, 1'b0);
        wait_done(cyc);
        check("len0_latency_le3", 32'(cyc <= 3), 1);
        check_queues_empty();

        // Address wrap at the top of the buffer
        push_job(12'hFFF, 12'h7FE, 12'h100, 16'd2);
        issue(12'hFFF, 12'h7FE, 12'h100, 16'd2, 1'b0);
        wait_done(cyc);
        check_queues_empty();

        // Negative result (sign bit set) and a positive single-pair result
        push_job(12'h300, 12'h400, 12'h0C0, 16'd1);
        issue(12'h300, 12'h400, 12'h0C0, 16'd1, 1'b0);
        wait_done(cyc);
        push_job(12'h310, 12'h410, 12'h0C1, 16'd1);
        issue(12'h310, 12'h410, 12'h0C1, 16'd1, 1'b0);
        wait_done(cyc);
        check_queues_empty();

        // Reset while waiting for the first take: job abandoned silently
        exp_rd_q.push_back({12'h050, 12'h060});
        exp_start_q.push_back(32'd2);
        issue(12'h050, 12'h060, 12'h0EE, 16'd3, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mac_start) begin seen = 1'b1; break; end
        end
        check("abort_start_seen", 32'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(cmd_ready), 1);
        check("abort_outputs", {done, out_wr_en, data_rd_en, mac_start}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_still_idle", {busy, cmd_ready}, 2'b01);
        check_queues_empty();

        // Job after reset runs normally
        push_job(12'h200, 12'h210, 12'h0EF, 16'd4);
        issue(12'h200, 12'h210, 12'h0EF, 16'd4, 1'b0);
        wait_done(cyc);
        check_queues_empty();

        // Command held during a job plus a stray mac_done in WAIT_TAKE
        push_job(12'h080, 12'h090, 12'h00A, 16'd2);
        push_job(12'h0A0, 12'h0B0, 12'h00B, 16'd1);
        issue(12'h080, 12'h090, 12'h00A, 16'd2, 1'b1);
        cmd_data_base = 12'h0A0; cmd_weight_base = 12'h0B0; cmd_out_addr = 12'h00B; cmd_len = 16'd1;
        seen = 1'b0;
        early = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cmd_ready) early++;
            if (mac_start) begin seen = 1'b1; break; end
        end
        check("held_start_seen", 32'(seen), 1);
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            if (cmd_ready) early++;
        end
        check("held_first_done", 32'(seen), 1);
        check("held_off_while_busy", early, 0);
        @(negedge clk);
        check("held_ready_after_done", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("held_second_accepted", 32'(busy), 1);
        wait_done(cyc);
        check_queues_empty();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
